// File: rtl/hypot_pkg.sv
// Shared types and width helpers for the sequential hypotenuse block.
package hypot_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SQUARE = 2'd1,
      ITER   = 2'd2,
      DONE   = 2'd3
   } state_t;

   function automatic int root_w(input int w);
      return w + 1;
   endfunction

   function automatic int sum_w(input int w);
      return 2 * w + 1;
   endfunction

endpackage

// File: rtl/isqrt_step.sv
// One restoring square-root digit: brings down a bit pair and decides one root bit.
module isqrt_step #(
   parameter int W = 8
) (
   input  logic [W+2:0] rem_in,
   input  logic [W:0]   root_in,
   input  logic [1:0]   pair,
   output logic [W+2:0] rem_out,
   output logic [W:0]   root_out
);

   logic [W+4:0] rem_sh;
   logic [W+2:0] trial;
   logic         take;

   // The remainder never exceeds twice the partial root, so W+3 bits hold it
   // after either branch; only the compare needs the full shifted width.
   always_comb begin
      rem_sh   = {rem_in, pair};
      trial    = {root_in, 2'b01};
      take     = (rem_sh >= {2'b00, trial});
      rem_out  = take ? (rem_sh[W+2:0] - trial) : rem_sh[W+2:0];
      root_out = {root_in[W-1:0], take};
   end

endmodule

// File: rtl/hypot_seq.sv
// Sequential integer hypotenuse: root = isqrt(x*x + y*y), one root bit per cycle.
// Optional round-to-nearest of the root is enabled by defining HYPOT_ROUND_EN.
//
// state  | meaning
// IDLE   | in_ready high, waiting for an operand pair
// SQUARE | registers x*x + y*y, arms the iteration counter
// ITER   | one root bit per cycle; on terminal count latches the result
// DONE   | out_valid held with a stable result until out_ready
module hypot_seq
   import hypot_pkg::*;
#(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [W-1:0] x,
   input  logic [W-1:0] y,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [W:0]   root,
   output logic         exact
);

   localparam int RW = root_w(W);
   localparam int SW = sum_w(W);
   localparam int CW = $clog2(W + 2);

   state_t        state;
   logic [W-1:0]  x_q;
   logic [W-1:0]  y_q;
   logic [SW:0]   sum_q;
   logic [RW+1:0] rem_q;
   logic [RW-1:0] part_q;
   logic [CW-1:0] cnt;

   logic [SW-1:0] sum_c;
   logic [RW+1:0] rem_nx;
   logic [RW-1:0] part_nx;
   logic [RW-1:0] root_fin;

   assign sum_c = SW'(x_q) * SW'(x_q) + SW'(y_q) * SW'(y_q);

   // sum_q is kept one bit wider than the sum so it splits into whole bit
   // pairs; it shifts left as pairs are consumed, top pair feeds the step.
   isqrt_step #(.W(W)) u_step (
      .rem_in   (rem_q),
      .root_in  (part_q),
      .pair     (sum_q[SW:SW-1]),
      .rem_out  (rem_nx),
      .root_out (part_nx)
   );

`ifdef HYPOT_ROUND_EN
   assign root_fin = part_q + RW'(rem_q > {2'b00, part_q});
`else
   assign root_fin = part_q;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         in_ready  <= 1'b0;
         out_valid <= 1'b0;
         x_q       <= '0;
         y_q       <= '0;
         sum_q     <= '0;
         rem_q     <= '0;
         part_q    <= '0;
         cnt       <= '0;
         root      <= '0;
         exact     <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (in_valid && in_ready) begin
                  x_q      <= x;
                  y_q      <= y;
                  in_ready <= 1'b0;
                  state    <= SQUARE;
               end else begin
                  in_ready <= 1'b1;
               end
            end
            SQUARE: begin
               sum_q  <= {1'b0, sum_c};
               rem_q  <= '0;
               part_q <= '0;
               cnt    <= CW'(RW);
               state  <= ITER;
            end
            ITER: begin
               if (cnt != '0) begin
                  rem_q  <= rem_nx;
                  part_q <= part_nx;
                  sum_q  <= {sum_q[SW-2:0], 2'b00};
                  cnt    <= cnt - CW'(1);
               end else begin
                  root      <= root_fin;
                  exact     <= (rem_q == '0);
                  out_valid <= 1'b1;
                  state     <= DONE;
               end
            end
            DONE: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  in_ready  <= 1'b1;
                  state     <= IDLE;
               end
            end
            default: begin
               in_ready  <= 1'b0;
               out_valid <= 1'b0;
               state     <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_hypot_seq.sv
// Scoreboard bench for hypot_seq (W=8); expectations follow HYPOT_ROUND_EN.
module tb_hypot_seq;

   localparam int W = 8;
`ifdef HYPOT_ROUND_EN
   localparam bit RND = 1'b1;
`else
   localparam bit RND = 1'b0;
`endif

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         in_valid = 1'b0;
   logic         in_ready;
   logic [W-1:0] x = '0;
   logic [W-1:0] y = '0;
   logic         out_valid;
   logic         out_ready = 1'b1;
   logic [W:0]   root;
   logic         exact;

   hypot_seq #(.W(W)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .x         (x),
      .y         (y),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .root      (root),
      .exact     (exact)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc++;

   typedef struct {
      logic [W:0] r;
      logic       e;
      int         acc;
   } exp_t;

   exp_t q[$];
   int   tests = 0;
   int   fails = 0;
   logic ov_prev = 1'b0;

   task automatic check(input string name, input int act, input int exp);
      tests++;
      if (act != exp) begin
         fails++;
         $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Monitor: latency on the rising edge of out_valid, data on each handshake.
   always @(negedge clk) begin
      if (out_valid && !ov_prev) begin
         if (q.size() == 0) check("unexpected_out_valid", 1, 0);
         else check("latency", cyc - q[0].acc, W + 3);
      end
      if (out_valid && out_ready) begin
         if (q.size() == 0) begin
            check("unexpected_result", 1, 0);
         end else begin
            check("root", int'(root), int'(q[0].r));
            check("exact", int'(exact), int'(q[0].e));
            void'(q.pop_front());
         end
      end
      ov_prev = out_valid;
   end

   task automatic send(input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [W:0] er, input logic ee, input bit push);
      int n = 0;
      while (!in_ready && n < 200) begin
         @(posedge clk); #1;
         n++;
      end
      if (!in_ready) begin
         check("in_ready_timeout", 0, 1);
         return;
      end
      in_valid = 1'b1;
      x = a;
      y = b;
      @(posedge clk); #1;
      in_valid = 1'b0;
      x = W'($urandom);
      y = W'($urandom);
      if (push) q.push_back('{er, ee, cyc});
   endtask

   task automatic drain();
      int n = 0;
      while ((q.size() != 0 || !in_ready) && n < 200) begin
         @(posedge clk); #1;
         n++;
      end
      check("drain_timeout", int'(n < 200), 1);
   endtask

   initial begin
      int h;
      int seen;
      #2;
      check("reset_out_valid", int'(out_valid), 0);
      check("reset_in_ready", int'(in_ready), 0);
      check("reset_root", int'(root), 0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      check("in_ready_before_edge", int'(in_ready), 0);
      @(posedge clk); #1;
      check("in_ready_after_edge", int'(in_ready), 1);

      send(8'd3,   8'd4,   9'd5, 1'b1, 1'b1);
      send(8'd0,   8'd0,   9'd0, 1'b1, 1'b1);
      send(8'd255, 8'd255, RND ? 9'd361 : 9'd360, 1'b0, 1'b1);
      send(8'd2,   8'd3,   RND ? 9'd4 : 9'd3, 1'b0, 1'b1);
      send(8'd1,   8'd1,   9'd1, 1'b0, 1'b1);
      send(8'd10,  8'd10,  9'd14, 1'b0, 1'b1);
      send(8'd7,   8'd24,  9'd25, 1'b1, 1'b1);
      send(8'd100, 8'd200, RND ? 9'd224 : 9'd223, 1'b0, 1'b1);
      drain();

      // Back-pressure: result must hold, no new accept.
      out_ready = 1'b0;
      send(8'd5, 8'd5, 9'd7, 1'b0, 1'b1);
      seen = 0;
      while (!out_valid && seen < 50) begin
         @(posedge clk); #1;
         seen++;
      end
      check("hold_wait_valid", int'(out_valid), 1);
      in_valid = 1'b1;
      repeat (20) begin
         @(posedge clk); #1;
         check("hold_out_valid", int'(out_valid), 1);
         check("hold_root", int'(root), 7);
         check("hold_in_ready", int'(in_ready), 0);
      end
      in_valid = 1'b0;
      out_ready = 1'b1;
      @(posedge clk); #1;
      h = cyc;
      check("post_hs_in_ready", int'(in_ready), 1);
      check("post_hs_out_valid", int'(out_valid), 0);
      send(8'd6, 8'd8, 9'd10, 1'b1, 1'b1);
      check("reaccept_cycle", cyc, h + 1);
      drain();

      // Input activity during ITER must not disturb the captured pair.
      send(8'd9, 8'd12, 9'd15, 1'b1, 1'b1);
      repeat (10) begin
         @(posedge clk); #1;
         in_valid = 1'($urandom);
         x = W'($urandom);
         y = W'($urandom);
      end
      in_valid = 1'b0;
      drain();

      // Reset in ITER: computation abandoned, no output.
      send(8'd100, 8'd200, 9'd0, 1'b0, 1'b0);
      repeat (5) begin
         @(posedge clk); #1;
      end
      rst_n = 1'b0;
      #1;
      check("midreset_out_valid", int'(out_valid), 0);
      check("midreset_in_ready", int'(in_ready), 0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;
      check("midreset_in_ready_up", int'(in_ready), 1);
      seen = 0;
      repeat (20) begin
         @(negedge clk);
         if (out_valid) seen++;
      end
      check("midreset_no_output", seen, 0);
      @(posedge clk); #1;
      send(8'd6, 8'd8, 9'd10, 1'b1, 1'b1);
      drain();

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
